// File: rtl/dispatch_ctrl_pkg.sv
// rtl/dispatch_ctrl_pkg.sv - shared state, unit-select and payload types for the dispatch controller
package dispatch_ctrl_pkg;

  typedef enum logic {
    ST_EMPTY = 1'b0,
    ST_HELD  = 1'b1
  } state_e;

  typedef enum logic [1:0] {
    UNIT_ALU = 2'd0,
    UNIT_LSU = 2'd1,
    UNIT_BRU = 2'd2
  } unit_e;

  typedef struct packed {
    logic        branch;
    logic        jump;
    logic        mem_read;
    logic        mem_write;
    logic        reg_write;
    logic        alu_src_imm;
    logic        alu_src_pc;
    logic [4:0]  rs1;
    logic [4:0]  rs2;
    logic [4:0]  rd;
    logic [31:0] imm;
    logic [1:0]  alu_op;
    logic [1:0]  write_data;
    logic [2:0]  load_size;
  } payload_t;

  // Control flow outranks memory access so a malformed branch+load still goes to the BRU.
  function automatic unit_e steer(input payload_t p);
    unit_e u;
    u = UNIT_ALU;
    if (p.branch || p.jump) begin
      u = UNIT_BRU;
    end else if (p.mem_read || p.mem_write) begin
      u = UNIT_LSU;
    end
    return u;
  endfunction

endpackage

// File: rtl/dispatch_scoreboard.sv
// rtl/dispatch_scoreboard.sv - register busy vector with same-cycle writeback bypass and hazard check
module dispatch_scoreboard
  import dispatch_ctrl_pkg::*;
(
  input  logic        i_clk,
  input  logic        i_rst,
  input  logic        i_wb_valid,
  input  logic [4:0]  i_wb_rd,
  input  payload_t    i_cand,
  input  logic        i_set,
  output logic        o_hazard,
  output logic [31:0] o_busy_vec
);

  logic [31:0] r_busy;
  logic [31:0] w_clear_mask;
  logic [31:0] w_set_mask;
  logic [31:0] w_busy_next_clear;
  logic        w_rs1_used;
  logic        w_rs2_used;
  logic        w_rs1_haz;
  logic        w_rs2_haz;
  logic        w_rd_haz;

  assign w_clear_mask      = i_wb_valid ? (32'd1 << i_wb_rd) : 32'd0;
  assign w_set_mask        = (i_set && i_cand.reg_write) ? (32'd1 << i_cand.rd) : 32'd0;
  assign w_busy_next_clear = r_busy & ~w_clear_mask;

  assign w_rs1_used = ~i_cand.alu_src_pc;
  assign w_rs2_used = i_cand.branch | i_cand.mem_write | ~i_cand.alu_src_imm;

  assign w_rs1_haz = w_rs1_used && (i_cand.rs1 != 5'd0) && w_busy_next_clear[i_cand.rs1];
  assign w_rs2_haz = w_rs2_used && (i_cand.rs2 != 5'd0) && w_busy_next_clear[i_cand.rs2];
  assign w_rd_haz  = i_cand.reg_write && (i_cand.rd != 5'd0) && w_busy_next_clear[i_cand.rd];

  assign o_hazard   = w_rs1_haz | w_rs2_haz | w_rd_haz;
  assign o_busy_vec = r_busy;

  // Set is OR-ed after the clear so a new producer of rd wins over a retiring one.
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      r_busy <= 32'd0;
    end else begin
      r_busy <= (w_busy_next_clear | w_set_mask) & 32'hFFFF_FFFE;
    end
  end

endmodule

// File: rtl/dispatch_ctrl.sv
// rtl/dispatch_ctrl.sv - single-entry dispatch stage steering decoded ops to ALU, LSU or BRU
module dispatch_ctrl
  import dispatch_ctrl_pkg::*;
(
  input  logic        i_clk,
  input  logic        i_rst,
  input  logic        i_in_valid,
  output logic        o_in_ready,
  input  logic        i_branch,
  input  logic        i_jump,
  input  logic        i_mem_read,
  input  logic        i_mem_write,
  input  logic        i_reg_write,
  input  logic        i_alu_src_imm,
  input  logic        i_alu_src_pc,
  input  logic [4:0]  i_rs1,
  input  logic [4:0]  i_rs2,
  input  logic [4:0]  i_rd,
  input  logic [31:0] i_imm,
  input  logic [1:0]  i_alu_op,
  input  logic [1:0]  i_write_data,
  input  logic [2:0]  i_load_size,
  output logic        o_alu_valid,
  output logic        o_lsu_valid,
  output logic        o_bru_valid,
  input  logic        i_alu_ready,
  input  logic        i_lsu_ready,
  input  logic        i_bru_ready,
  output payload_t    o_payload,
  input  logic        i_wb_valid,
  input  logic [4:0]  i_wb_rd,
  input  logic        i_flush,
  output logic [31:0] o_busy_vec,
  output logic [31:0] o_dispatch_count
);

  state_e      r_state;
  payload_t    r_payload;
  logic        r_alu_valid;
  logic        r_lsu_valid;
  logic        r_bru_valid;
  logic [31:0] r_count;

  payload_t    w_in;
  unit_e       w_in_unit;
  logic        w_fire;
  logic        w_accept;
  logic        w_hazard;

  assign w_in = '{
    branch:      i_branch,
    jump:        i_jump,
    mem_read:    i_mem_read,
    mem_write:   i_mem_write,
    reg_write:   i_reg_write,
    alu_src_imm: i_alu_src_imm,
    alu_src_pc:  i_alu_src_pc,
    rs1:         i_rs1,
    rs2:         i_rs2,
    rd:          i_rd,
    imm:         i_imm,
    alu_op:      i_alu_op,
    write_data:  i_write_data,
    load_size:   i_load_size
  };

  assign w_in_unit = steer(w_in);

  // Flush masks the valids in its own cycle so a flushed op can never fire or be counted.
  assign o_alu_valid = r_alu_valid & ~i_flush;
  assign o_lsu_valid = r_lsu_valid & ~i_flush;
  assign o_bru_valid = r_bru_valid & ~i_flush;

  assign w_fire     = (o_alu_valid & i_alu_ready) | (o_lsu_valid & i_lsu_ready) |
                      (o_bru_valid & i_bru_ready);
  assign o_in_ready = ~i_rst & ((r_state == ST_EMPTY) | w_fire) & ~w_hazard & ~i_flush;
  assign w_accept   = i_in_valid & o_in_ready;

  assign o_payload        = r_payload;
  assign o_dispatch_count = r_count;

  dispatch_scoreboard u_scoreboard (
    .i_clk      (i_clk),
    .i_rst      (i_rst),
    .i_wb_valid (i_wb_valid),
    .i_wb_rd    (i_wb_rd),
    .i_cand     (w_in),
    .i_set      (w_accept),
    .o_hazard   (w_hazard),
    .o_busy_vec (o_busy_vec)
  );

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      r_state     <= ST_EMPTY;
      r_payload   <= '0;
      r_alu_valid <= 1'b0;
      r_lsu_valid <= 1'b0;
      r_bru_valid <= 1'b0;
      r_count     <= 32'd0;
    end else begin
      if (w_fire) begin
        r_count <= r_count + 32'd1;
      end
      if (i_flush) begin
        r_state     <= ST_EMPTY;
        r_alu_valid <= 1'b0;
        r_lsu_valid <= 1'b0;
        r_bru_valid <= 1'b0;
      end else if (w_accept) begin
        r_state     <= ST_HELD;
        r_payload   <= w_in;
        r_alu_valid <= (w_in_unit == UNIT_ALU);
        r_lsu_valid <= (w_in_unit == UNIT_LSU);
        r_bru_valid <= (w_in_unit == UNIT_BRU);
      end else if (w_fire) begin
        r_state     <= ST_EMPTY;
        r_alu_valid <= 1'b0;
        r_lsu_valid <= 1'b0;
        r_bru_valid <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_dispatch_ctrl.sv
// tb/tb_dispatch_ctrl.sv - steering table, hazard sequences and fire scoreboard for dispatch_ctrl
module tb_dispatch_ctrl;
  import dispatch_ctrl_pkg::*;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        in_valid = 1'b0;
  logic        alu_ready = 1'b1;
  logic        lsu_ready = 1'b1;
  logic        bru_ready = 1'b1;
  logic        wb_valid = 1'b0;
  logic [4:0]  wb_rd = 5'd0;
  logic        flush = 1'b0;
  payload_t    drv = '0;

  logic        in_ready;
  logic        alu_valid;
  logic        lsu_valid;
  logic        bru_valid;
  payload_t    payload;
  logic [31:0] busy_vec;
  logic [31:0] dispatch_count;

  dispatch_ctrl dut (
    .i_clk            (clk),
    .i_rst            (rst),
    .i_in_valid       (in_valid),
    .o_in_ready       (in_ready),
    .i_branch         (drv.branch),
    .i_jump           (drv.jump),
    .i_mem_read       (drv.mem_read),
    .i_mem_write      (drv.mem_write),
    .i_reg_write      (drv.reg_write),
    .i_alu_src_imm    (drv.alu_src_imm),
    .i_alu_src_pc     (drv.alu_src_pc),
    .i_rs1            (drv.rs1),
    .i_rs2            (drv.rs2),
    .i_rd             (drv.rd),
    .i_imm            (drv.imm),
    .i_alu_op         (drv.alu_op),
    .i_write_data     (drv.write_data),
    .i_load_size      (drv.load_size),
    .o_alu_valid      (alu_valid),
    .o_lsu_valid      (lsu_valid),
    .o_bru_valid      (bru_valid),
    .i_alu_ready      (alu_ready),
    .i_lsu_ready      (lsu_ready),
    .i_bru_ready      (bru_ready),
    .o_payload        (payload),
    .i_wb_valid       (wb_valid),
    .i_wb_rd          (wb_rd),
    .i_flush          (flush),
    .o_busy_vec       (busy_vec),
    .o_dispatch_count (dispatch_count)
  );

  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_bad = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Unit codes: 0 ALU, 1 LSU, 2 BRU; one-hot valid order {bru, lsu, alu}.
  function automatic int exp_unit(input payload_t p);
    if (p.branch || p.jump) return 2;
    if (p.mem_read || p.mem_write) return 1;
    return 0;
  endfunction

  // ctl = {branch, jump, mem_read, mem_write, reg_write, alu_src_imm, alu_src_pc}
  function automatic payload_t ins(input logic [6:0] ctl, input logic [4:0] rs1,
                                   input logic [4:0] rs2, input logic [4:0] rd,
                                   input logic [31:0] imm);
    payload_t p;
    p = '0;
    {p.branch, p.jump, p.mem_read, p.mem_write, p.reg_write, p.alu_src_imm, p.alu_src_pc} = ctl;
    p.rs1 = rs1;
    p.rs2 = rs2;
    p.rd = rd;
    p.imm = imm;
    p.alu_op = imm[1:0];
    p.write_data = imm[3:2];
    p.load_size = imm[6:4];
    return p;
  endfunction

  typedef struct {
    int       unit;
    payload_t p;
  } exp_t;

  exp_t        q[$];
  logic [31:0] m_busy = 32'd0;
  logic [31:0] m_cnt = 32'd0;

  always @(negedge clk) begin : monitor
    logic [2:0] v;
    logic       fire;
    exp_t       e;
    v = {bru_valid, lsu_valid, alu_valid};
    fire = |(v & {bru_ready, lsu_ready, alu_ready});
    if (rst) begin
      check("rst_valids", {61'd0, v}, 64'd0);
      check("rst_in_ready", {63'd0, in_ready}, 64'd0);
      check("rst_busy", {32'd0, busy_vec}, 64'd0);
      check("rst_count", {32'd0, dispatch_count}, 64'd0);
      check("rst_payload", {3'd0, payload}, 64'd0);
      q.delete();
      m_busy = 32'd0;
      m_cnt = 32'd0;
    end else begin
      check("busy_vec", {32'd0, busy_vec}, {32'd0, m_busy});
      check("dispatch_count", {32'd0, dispatch_count}, {32'd0, m_cnt});
      if (flush) begin
        check("flush_valids", {61'd0, v}, 64'd0);
        if (q.size() > 0) void'(q.pop_front());
      end else begin
        check("valid_onehot", {61'd0, v},
              {61'd0, (q.size() > 0) ? (3'b001 << q[0].unit) : 3'b000});
        if (fire) begin
          if (q.size() == 0) begin
            n_cmp++;
            n_bad++;
            $display("FAIL fire_unexpected: got a fire, expected none (valids %b)", v);
          end else begin
            e = q.pop_front();
            check("fire_payload", {3'd0, payload}, {3'd0, e.p});
            m_cnt = m_cnt + 32'd1;
          end
        end
      end
      if (wb_valid) m_busy[wb_rd] = 1'b0;
      if (in_valid && in_ready) begin
        if (drv.reg_write) m_busy[drv.rd] = 1'b1;
        e.unit = exp_unit(drv);
        e.p = drv;
        q.push_back(e);
      end
      m_busy[0] = 1'b0;
    end
  end

  task automatic wb_all();
    for (int r = 1; r < 32; r++) begin
      wb_valid = 1'b1;
      wb_rd = r[4:0];
      tick();
    end
    wb_valid = 1'b0;
    tick();
  endtask

  typedef struct {
    payload_t p;
    logic     exp_ready;
  } vec_t;

  vec_t        tbl[13];
  payload_t    held;
  logic [31:0] c0;
  logic [31:0] busy_b;

  initial begin
    tbl[0]  = '{ins(7'b0000100, 5'd1, 5'd2, 5'd5, 32'h0000_0011), 1'b1};
    tbl[1]  = '{ins(7'b0000110, 5'd5, 5'd0, 5'd6, 32'h0000_0001), 1'b0};
    tbl[2]  = '{ins(7'b0000111, 5'd5, 5'd5, 5'd6, 32'h1234_5000), 1'b1};
    tbl[3]  = '{ins(7'b1000010, 5'd1, 5'd5, 5'd0, 32'hFFFF_FFF0), 1'b0};
    tbl[4]  = '{ins(7'b0100111, 5'd0, 5'd0, 5'd7, 32'h0000_0100), 1'b1};
    tbl[5]  = '{ins(7'b0010110, 5'd1, 5'd6, 5'd8, 32'h0000_0024), 1'b1};
    tbl[6]  = '{ins(7'b0001010, 5'd1, 5'd6, 5'd0, 32'h0000_0008), 1'b0};
    tbl[7]  = '{ins(7'b0001010, 5'd1, 5'd2, 5'd0, 32'h0000_007C), 1'b1};
    tbl[8]  = '{ins(7'b0000100, 5'd1, 5'd2, 5'd5, 32'h0000_0003), 1'b0};
    tbl[9]  = '{ins(7'b1010000, 5'd1, 5'd2, 5'd0, 32'hA5A5_A5A5), 1'b1};
    tbl[10] = '{ins(7'b0000010, 5'd0, 5'd0, 5'd5, 32'h0000_0042), 1'b1};
    tbl[11] = '{ins(7'b0010110, 5'd8, 5'd0, 5'd9, 32'h0000_0004), 1'b0};
    tbl[12] = '{ins(7'b0100110, 5'd7, 5'd0, 5'd9, 32'h0000_0010), 1'b0};

    rst = 1'b1;
    repeat (3) tick();
    rst = 1'b0;
    tick();

    for (int i = 0; i < 13; i++) begin
      drv = tbl[i].p;
      in_valid = 1'b1;
      @(negedge clk);
      check($sformatf("tbl%0d_in_ready", i), {63'd0, in_ready}, {63'd0, tbl[i].exp_ready});
      tick();
      in_valid = 1'b0;
      tick();
      tick();
    end
    wb_all();

    // add x5,x1,x2 then writeback of x5
    c0 = m_cnt;
    drv = ins(7'b0000100, 5'd1, 5'd2, 5'd5, 32'd0);
    in_valid = 1'b1;
    @(negedge clk);
    check("add_in_ready", {63'd0, in_ready}, 64'd1);
    tick();
    in_valid = 1'b0;
    @(negedge clk);
    check("add_alu_valid", {63'd0, alu_valid}, 64'd1);
    check("add_busy5", {63'd0, busy_vec[5]}, 64'd1);
    tick();
    @(negedge clk);
    check("add_count", {32'd0, dispatch_count}, {32'd0, c0 + 32'd1});
    check("add_alu_idle", {63'd0, alu_valid}, 64'd0);
    tick();
    wb_valid = 1'b1;
    wb_rd = 5'd5;
    tick();
    wb_valid = 1'b0;
    @(negedge clk);
    check("wb_busy5", {63'd0, busy_vec[5]}, 64'd0);
    tick();

    // lw x3 then dependent addi x4,x3,1 with same-cycle writeback bypass
    drv = ins(7'b0010110, 5'd1, 5'd0, 5'd3, 32'd0);
    in_valid = 1'b1;
    tick();
    drv = ins(7'b0000110, 5'd3, 5'd0, 5'd4, 32'd1);
    @(negedge clk);
    check("raw_stall_in_ready", {63'd0, in_ready}, 64'd0);
    tick();
    wb_valid = 1'b1;
    wb_rd = 5'd3;
    @(negedge clk);
    check("raw_bypass_in_ready", {63'd0, in_ready}, 64'd1);
    tick();
    in_valid = 1'b0;
    wb_valid = 1'b0;
    tick();
    wb_all();

    // beq stalled by bru_ready=0 for three cycles
    bru_ready = 1'b0;
    held = ins(7'b1000000, 5'd1, 5'd2, 5'd0, 32'hFFFF_FF80);
    drv = held;
    in_valid = 1'b1;
    tick();
    drv = ins(7'b0000100, 5'd1, 5'd2, 5'd9, 32'd0);
    for (int k = 0; k < 3; k++) begin
      @(negedge clk);
      check($sformatf("stall%0d_bru_valid", k), {63'd0, bru_valid}, 64'd1);
      check($sformatf("stall%0d_payload", k), {3'd0, payload}, {3'd0, held});
      check($sformatf("stall%0d_in_ready", k), {63'd0, in_ready}, 64'd0);
      tick();
    end
    bru_ready = 1'b1;
    in_valid = 1'b0;
    @(negedge clk);
    check("stall_release_valid", {63'd0, bru_valid}, 64'd1);
    tick();
    @(negedge clk);
    check("stall_empty", {61'd0, bru_valid, lsu_valid, alu_valid}, 64'd0);
    tick();

    // four independent ALU ops back to back
    c0 = m_cnt;
    for (int k = 0; k < 4; k++) begin
      drv = ins(7'b0000100, 5'd1, 5'd2, 5'(10 + k), 32'(k));
      in_valid = 1'b1;
      @(negedge clk);
      check($sformatf("b2b%0d_in_ready", k), {63'd0, in_ready}, 64'd1);
      if (k > 0) check($sformatf("b2b%0d_alu_valid", k), {63'd0, alu_valid}, 64'd1);
      tick();
    end
    in_valid = 1'b0;
    @(negedge clk);
    check("b2b_last_valid", {63'd0, alu_valid}, 64'd1);
    tick();
    @(negedge clk);
    check("b2b_count", {32'd0, dispatch_count}, {32'd0, c0 + 32'd4});
    check("b2b_idle", {63'd0, alu_valid}, 64'd0);
    tick();

    // sw held then flushed
    lsu_ready = 1'b0;
    drv = ins(7'b0001010, 5'd1, 5'd2, 5'd0, 32'd12);
    in_valid = 1'b1;
    tick();
    in_valid = 1'b0;
    @(negedge clk);
    check("sw_lsu_valid", {63'd0, lsu_valid}, 64'd1);
    tick();
    c0 = m_cnt;
    busy_b = m_busy;
    flush = 1'b1;
    @(negedge clk);
    check("flush_cycle_lsu_valid", {63'd0, lsu_valid}, 64'd0);
    tick();
    flush = 1'b0;
    lsu_ready = 1'b1;
    @(negedge clk);
    check("flush_next_lsu_valid", {63'd0, lsu_valid}, 64'd0);
    check("flush_count", {32'd0, dispatch_count}, {32'd0, c0});
    check("flush_busy", {32'd0, busy_vec}, {32'd0, busy_b});
    tick();
    wb_all();

    // writeback and new producer of x7 in one cycle; rd=x0 never marked busy
    drv = ins(7'b0100111, 5'd0, 5'd0, 5'd7, 32'd64);
    in_valid = 1'b1;
    tick();
    in_valid = 1'b0;
    @(negedge clk);
    check("jal_busy7", {63'd0, busy_vec[7]}, 64'd1);
    tick();
    drv = ins(7'b0000100, 5'd1, 5'd2, 5'd7, 32'd0);
    in_valid = 1'b1;
    wb_valid = 1'b1;
    wb_rd = 5'd7;
    @(negedge clk);
    check("set_clr_in_ready", {63'd0, in_ready}, 64'd1);
    tick();
    in_valid = 1'b0;
    wb_valid = 1'b0;
    @(negedge clk);
    check("set_wins_busy7", {63'd0, busy_vec[7]}, 64'd1);
    tick();
    drv = ins(7'b0000100, 5'd1, 5'd2, 5'd0, 32'd0);
    in_valid = 1'b1;
    wb_valid = 1'b1;
    wb_rd = 5'd0;
    tick();
    in_valid = 1'b0;
    wb_valid = 1'b0;
    tick();
    @(negedge clk);
    check("x0_never_busy", {63'd0, busy_vec[0]}, 64'd0);
    tick();

    // reset while an ALU op is held
    alu_ready = 1'b0;
    drv = ins(7'b0000100, 5'd1, 5'd2, 5'd14, 32'd0);
    in_valid = 1'b1;
    tick();
    in_valid = 1'b0;
    @(negedge clk);
    check("pre_rst_alu_valid", {63'd0, alu_valid}, 64'd1);
    #2;
    rst = 1'b1;
    #1;
    check("async_rst_valids", {61'd0, bru_valid, lsu_valid, alu_valid}, 64'd0);
    check("async_rst_busy", {32'd0, busy_vec}, 64'd0);
    tick();
    tick();
    alu_ready = 1'b1;
    rst = 1'b0;
    @(negedge clk);
    check("post_rst_count", {32'd0, dispatch_count}, 64'd0);
    check("post_rst_alu_valid", {63'd0, alu_valid}, 64'd0);
    tick();
    tick();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/dispatch_ctrl.md
DISPATCH_CTRL -- requirements
Module: dispatch_ctrl

Interface
REQ-001 The module SHALL have one clock and reset: clk input 1, rising-edge; rst input 1, asynchronous, active-high.
REQ-002 The module SHALL have an upstream handshake: in_valid input 1; in_ready output 1, accept when both high at clk edge.
REQ-003 The module SHALL have decoded fields, all inputs: branch 1, jump 1, mem_read 1, mem_write 1, reg_write 1, alu_src_imm 1, alu_src_pc 1, rs1 5, rs2 5, rd 5, imm 32, alu_op 2, write_data 2, load_size 3.
REQ-004 The module SHALL have downstream handshakes: alu_valid/lsu_valid/bru_valid outputs 1; alu_ready/lsu_ready/bru_ready inputs 1.
REQ-005 The module SHALL have one registered payload output, shared by all units, equal to the held copy of the REQ-003 fields.
REQ-006 The module SHALL have writeback and flush inputs: wb_valid 1, wb_rd 5, flush 1.
REQ-007 The module SHALL have status outputs: busy_vec output 32, scoreboard; dispatch_count output 32, instructions dispatched.

Function
REQ-008 The module SHALL implement a 2-state FSM: EMPTY (no held instruction) and HELD (one instruction in the payload register).
REQ-009 The module SHALL steer by priority: branch|jump -> BRU; else mem_read|mem_write -> LSU; else ALU.
REQ-010 In HELD, the module SHALL raise exactly one of alu_valid/lsu_valid/bru_valid, selected by REQ-009; in EMPTY all three SHALL be 0.
REQ-011 Fire SHALL be the selected valid AND its ready; on fire with no new accept the FSM SHALL go HELD->EMPTY.
REQ-012 The module SHALL treat rs1 as used when !alu_src_pc, and rs2 as used when branch|mem_write|!alu_src_imm.
REQ-013 The module SHALL define a hazard when a used source, or rd with reg_write=1, is not x0 and has its bit set in busy_next_clear.
REQ-014 busy_next_clear SHALL be busy_vec with bit wb_rd cleared when wb_valid=1, so writeback bypasses in the same cycle.
REQ-015 in_ready SHALL be (EMPTY or fire) AND !hazard AND !flush; it is combinational, 0-cycle.
REQ-016 On accept the module SHALL capture the fields into the payload, go to or stay in HELD, and set busy[rd] if reg_write=1 and rd!=0.
REQ-017 The module SHALL allow fire and accept in the same cycle, giving back-to-back dispatch of 1 instruction per cycle.
REQ-018 When wb_valid clears and an accept sets the same rd in one cycle, set SHALL win and the bit SHALL end at 1.
REQ-019 busy_vec[0] SHALL always be 0; a wb to rd=0 SHALL be ignored.
REQ-020 flush SHALL drop the held instruction, force EMPTY next cycle and deassert all valids that cycle, and SHALL NOT clear busy_vec, because in-flight ops still write back.
REQ-021 dispatch_count SHALL increment by 1 per fire, wrap modulo 2^32, and not count a flushed instruction.
REQ-022 The payload SHALL hold stable while HELD and not fired; payload is don't-care in EMPTY.

Reset
REQ-023 While rst=1 the module SHALL hold the FSM at EMPTY, busy_vec=0, dispatch_count=0, payload=0, and all valids=0; in_ready is 0 during reset.
REQ-024 A rst assertion mid-HELD SHALL drop the instruction without a fire.

Structure
REQ-025 A shared package SHALL hold the state enum (EMPTY, HELD), the unit-select enum (ALU, LSU, BRU), and the payload struct of the REQ-003 fields.
REQ-026 The design SHALL have one sub-module, dispatch_scoreboard, holding the busy vector, set/clear logic, and hazard check; the FSM, steering, and counter SHALL be in the top.

Verification
REQ-027 Scenario: add x5,x1,x2 with alu_ready=1 -> alu_valid the next cycle, busy_vec[5]=1, dispatch_count=1; wb_rd=5 -> busy_vec[5]=0.
REQ-028 Scenario: lw x3 accepted, then addi x4,x3,1 offered with no wb -> in_ready=0; wb_valid=1 with wb_rd=3 in the same cycle -> in_ready=1 (bypass).
REQ-029 Scenario: beq x1,x2 with bru_ready=0 for 3 cycles -> bru_valid held with a stable payload and in_ready=0; bru_ready=1 -> fire, EMPTY.
REQ-030 Scenario: 4 independent ALU ops, in_valid=1 and alu_ready=1 continuously -> 4 dispatches in 4 consecutive cycles, dispatch_count=4.
REQ-031 Scenario: sw in HELD with flush=1 -> lsu_valid=0 the next cycle, dispatch_count unchanged, busy_vec unchanged.
REQ-032 Scenario: wb rd=7 and accept of an instruction with rd=7 in the same cycle -> busy_vec[7]=1; instruction with rd=0 and reg_write=1 -> busy_vec[0]=0.
